alu_arbiter: RTL and testbench



---
 rtl/alu_arbiter.sv | 126 ++++++++++++
 tb/tb_alu_arbiter.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between the EX stage (requester 0)
// and the branch/compare unit (requester 1). Round-robin grant, operands are
// registered toward the ALU, and the result is captured and held until the
// winning requester takes it (optionally dropped after RSP_TIMEOUT cycles).
module alu_arbiter #(
    parameter int DW          = 32,
    parameter int RSP_TIMEOUT = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [5:0]    req0_op,
    input  logic [4:0]    req0_shamt,
    input  logic [DW-1:0] req0_src1,
    input  logic [DW-1:0] req0_src2,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [5:0]    req1_op,
    input  logic [4:0]    req1_shamt,
    input  logic [DW-1:0] req1_src1,
    input  logic [DW-1:0] req1_src2,
    output logic          rsp0_valid,
    input  logic          rsp0_ready,
    output logic          rsp1_valid,
    input  logic          rsp1_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_equal,
    output logic [5:0]    alu_ctr,
    output logic [4:0]    alu_shamt,
    output logic [DW-1:0] alu_src1,
    output logic [DW-1:0] alu_src2,
    input  logic [DW-1:0] alu_out,
    input  logic          alu_equal,
    output logic          busy,
    output logic          drop_err
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    localparam bit            TO_EN    = (RSP_TIMEOUT > 0);
    localparam int            CW       = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((RSP_TIMEOUT > 0) ? RSP_TIMEOUT - 1 : 0);

    state_t        state;
    logic          last_grant;   // requester that won most recently
    logic          owner;        // requester whose result is in flight
    logic [CW-1:0] cnt;          // DONE cycles spent waiting for the owner
    logic          grant0;
    logic          grant1;
    logic          rsp_hs;

    // Round-robin grant; only one ready may ever be high, and only in IDLE.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE) begin
            if (req0_valid && req1_valid) begin
                grant0 = last_grant;
                grant1 = !last_grant;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign rsp0_valid = (state == DONE) && !owner;
    assign rsp1_valid = (state == DONE) && owner;
    assign rsp_hs     = owner ? rsp1_ready : rsp0_ready;
    assign busy       = (state != IDLE);

    // Issue / execute / respond sequencing; alu_* only move on a request handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            cnt        <= '0;
            alu_ctr    <= '0;
            alu_shamt  <= '0;
            alu_src1   <= '0;
            alu_src2   <= '0;
            rsp_data   <= '0;
            rsp_equal  <= 1'b0;
            drop_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        alu_ctr    <= grant1 ? req1_op    : req0_op;
                        alu_shamt  <= grant1 ? req1_shamt : req0_shamt;
                        alu_src1   <= grant1 ? req1_src1  : req0_src1;
                        alu_src2   <= grant1 ? req1_src2  : req0_src2;
                        owner      <= grant1;
                        last_grant <= grant1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data  <= alu_out;
                    rsp_equal <= alu_equal;
                    cnt       <= '0;
                    state     <= DONE;
                end
                DONE: begin
                    // A handshake on the would-be timeout cycle still delivers.
                    if (rsp_hs) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (TO_EN) begin
                        if (cnt == CNT_LAST) begin
                            cnt      <= '0;
                            drop_err <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a behavioural ALU sits behind each DUT; expected
// grants follow the round-robin rule and expected results come from the
// requested operands, never from the DUT's own registers.
module tb_alu_arbiter;
    localparam int DW = 32;
    localparam logic [5:0] OP_ADD = 6'b100000, OP_SUB = 6'b100010, OP_SLT = 6'b101010;
    localparam logic [5:0] OP_SLL = 6'b000000, OP_AND = 6'b100100, OP_OR  = 6'b100101;
    localparam logic [5:0] OP_BAD = 6'b111111;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          req0_valid, req1_valid, rsp0_ready, rsp1_ready;
    logic [5:0]    req0_op, req1_op;
    logic [4:0]    req0_shamt, req1_shamt;
    logic [DW-1:0] req0_src1, req0_src2, req1_src1, req1_src2;

    // instance a: no timeout
    logic          a_req0_ready, a_req1_ready, a_rsp0_valid, a_rsp1_valid;
    logic          a_rsp_equal, a_busy, a_drop_err, a_eq;
    logic [DW-1:0] a_rsp_data, a_src1, a_src2, a_out;
    logic [5:0]    a_ctr;
    logic [4:0]    a_shamt;
    // instance b: RSP_TIMEOUT = 4
    logic          b_req0_ready, b_req1_ready, b_rsp0_valid, b_rsp1_valid;
    logic          b_rsp_equal, b_busy, b_drop_err, b_eq;
    logic [DW-1:0] b_rsp_data, b_src1, b_src2, b_out;
    logic [5:0]    b_ctr;
    logic [4:0]    b_shamt;

    int checks = 0;
    int fails  = 0;
    logic [5:0] ops [8] = '{OP_ADD, OP_SUB, OP_SLT, OP_SLL, OP_AND, OP_OR, OP_BAD, 6'b001101};

    // Behavioural ALU: {equal, result}; unsupported opcodes give 0 with equal=1.
    function automatic logic [DW:0] alu_fn(input logic [5:0] op, input logic [4:0] sh,
                                           input logic [DW-1:0] x, input logic [DW-1:0] y);
        logic [DW-1:0] r;
        logic          e;
        e = (x == y);
        case (op)
            OP_ADD:  r = x + y;
            OP_SUB:  r = x - y;
            OP_SLT:  r = {{(DW-1){1'b0}}, ($signed(x) < $signed(y))};
            OP_SLL:  r = y << sh;
            OP_AND:  r = x & y;
            OP_OR:   r = x | y;
            default: begin r = '0; e = 1'b1; end
        endcase
        return {e, r};
    endfunction

    assign {a_eq, a_out} = alu_fn(a_ctr, a_shamt, a_src1, a_src2);
    assign {b_eq, b_out} = alu_fn(b_ctr, b_shamt, b_src1, b_src2);

    alu_arbiter #(.DW(DW), .RSP_TIMEOUT(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(a_req0_ready), .req0_op(req0_op),
        .req0_shamt(req0_shamt), .req0_src1(req0_src1), .req0_src2(req0_src2),
        .req1_valid(req1_valid), .req1_ready(a_req1_ready), .req1_op(req1_op),
        .req1_shamt(req1_shamt), .req1_src1(req1_src1), .req1_src2(req1_src2),
        .rsp0_valid(a_rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(a_rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_data(a_rsp_data), .rsp_equal(a_rsp_equal),
        .alu_ctr(a_ctr), .alu_shamt(a_shamt), .alu_src1(a_src1), .alu_src2(a_src2),
        .alu_out(a_out), .alu_equal(a_eq), .busy(a_busy), .drop_err(a_drop_err)
    );

    alu_arbiter #(.DW(DW), .RSP_TIMEOUT(4)) dut_to (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(b_req0_ready), .req0_op(req0_op),
        .req0_shamt(req0_shamt), .req0_src1(req0_src1), .req0_src2(req0_src2),
        .req1_valid(req1_valid), .req1_ready(b_req1_ready), .req1_op(req1_op),
        .req1_shamt(req1_shamt), .req1_src1(req1_src1), .req1_src2(req1_src2),
        .rsp0_valid(b_rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(b_rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_data(b_rsp_data), .rsp_equal(b_rsp_equal),
        .alu_ctr(b_ctr), .alu_shamt(b_shamt), .alu_src1(b_src1), .alu_src2(b_src2),
        .alu_out(b_out), .alu_equal(b_eq), .busy(b_busy), .drop_err(b_drop_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
        req0_op = '0; req1_op = '0; req0_shamt = '0; req1_shamt = '0;
        req0_src1 = '0; req0_src2 = '0; req1_src1 = '0; req1_src2 = '0;
    endtask

    task automatic reset_dut();
        rst_n = 0;
        idle_inputs();
        #2;
        tick();
        rst_n = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        #2;
        checks++;
        if ({a_req0_ready, a_req1_ready, a_rsp0_valid, a_rsp1_valid, a_busy, a_drop_err, a_rsp_equal} !== 7'b0) begin
            fails++; $display("FAIL reset_flags_a: got %b want 0", {a_req0_ready, a_req1_ready, a_rsp0_valid, a_rsp1_valid, a_busy, a_drop_err, a_rsp_equal});
        end
        checks++;
        if ({a_ctr, a_shamt, a_src1, a_src2, a_rsp_data} !== '0) begin
            fails++; $display("FAIL reset_regs_a: got ctr=%h sh=%h s1=%h s2=%h d=%h want 0", a_ctr, a_shamt, a_src1, a_src2, a_rsp_data);
        end
        tick();
        rst_n = 1;
        @(negedge clk);
        checks++;
        if ({b_req0_ready, b_req1_ready, b_rsp0_valid, b_rsp1_valid, b_busy, b_drop_err, b_rsp_data, b_ctr} !== '0) begin
            fails++; $display("FAIL reset_b: got busy=%b drop=%b data=%h ctr=%h want 0", b_busy, b_drop_err, b_rsp_data, b_ctr);
        end
        tick();
    endtask

    task automatic test_single();
        reset_dut();
        req0_valid = 1; req0_op = OP_ADD; req0_src1 = 5; req0_src2 = 7; rsp0_ready = 1;
        @(negedge clk);
        checks++;
        if ({a_req0_ready, a_req1_ready} !== 2'b10) begin
            fails++; $display("FAIL single_grant: got %b want 10", {a_req0_ready, a_req1_ready});
        end
        tick();
        req0_valid = 0;
        @(negedge clk);
        checks++;
        if ({a_busy, a_rsp0_valid, a_ctr, a_src1, a_src2} !== {1'b1, 1'b0, OP_ADD, 32'd5, 32'd7}) begin
            fails++; $display("FAIL single_exec: got busy=%b v=%b ctr=%b s1=%0d s2=%0d want 1 0 100000 5 7", a_busy, a_rsp0_valid, a_ctr, a_src1, a_src2);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({a_rsp0_valid, a_rsp1_valid, a_rsp_equal, a_rsp_data} !== {1'b1, 1'b0, 1'b0, 32'd12}) begin
            fails++; $display("FAIL single_rsp: got v0=%b v1=%b eq=%b d=%0d want 1 0 0 12", a_rsp0_valid, a_rsp1_valid, a_rsp_equal, a_rsp_data);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({a_busy, a_rsp0_valid} !== 2'b00) begin
            fails++; $display("FAIL single_idle: got busy=%b v0=%b want 0 0", a_busy, a_rsp0_valid);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_round_robin();
        int w;
        logic [DW:0] e;
        reset_dut();
        req0_valid = 1; req0_op = OP_SUB; req0_src1 = 9; req0_src2 = 9;
        req1_valid = 1; req1_op = OP_SLT; req1_src1 = 3; req1_src2 = 4;
        rsp0_ready = 1; rsp1_ready = 1;
        for (int k = 0; k < 4; k++) begin
            w = k % 2;
            e = (w == 0) ? {1'b1, 32'd0} : {1'b0, 32'd1};
            @(negedge clk);
            checks++;
            if ({a_req0_ready, a_req1_ready} !== ((w == 1) ? 2'b01 : 2'b10)) begin
                fails++; $display("FAIL rr_grant%0d: got %b want winner %0d", k, {a_req0_ready, a_req1_ready}, w);
            end
            tick();
            tick();
            @(negedge clk);
            checks++;
            if ({a_rsp0_valid, a_rsp1_valid, a_rsp_equal, a_rsp_data} !== {(w == 0), (w == 1), e}) begin
                fails++; $display("FAIL rr_rsp%0d: got v=%b%b eq=%b d=%0d want owner %0d eq=%b d=%0d", k, a_rsp0_valid, a_rsp1_valid, a_rsp_equal, a_rsp_data, w, e[DW], e[DW-1:0]);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_backpressure();
        reset_dut();
        req1_valid = 1; req1_op = OP_SLL; req1_src1 = 0; req1_src2 = 1; req1_shamt = 4;
        @(negedge clk);
        checks++;
        if ({a_req0_ready, a_req1_ready} !== 2'b01) begin
            fails++; $display("FAIL bp_grant: got %b want 01", {a_req0_ready, a_req1_ready});
        end
        tick();
        req1_valid = 0; req0_valid = 1; req0_op = OP_ADD; req0_src1 = 1; req0_src2 = 1;
        @(negedge clk);
        checks++;
        if (a_req0_ready !== 1'b0) begin
            fails++; $display("FAIL bp_exec_ready: got %b want 0", a_req0_ready);
        end
        tick();
        for (int i = 0; i < 6; i++) begin
            if (i == 5) rsp1_ready = 1;
            @(negedge clk);
            checks++;
            if ({a_rsp1_valid, a_rsp0_valid, a_req0_ready, a_rsp_data, a_ctr} !== {3'b100, 32'd16, OP_SLL}) begin
                fails++; $display("FAIL bp_hold%0d: got v1=%b v0=%b r0=%b d=%0d ctr=%b want 1 0 0 16 000000", i, a_rsp1_valid, a_rsp0_valid, a_req0_ready, a_rsp_data, a_ctr);
            end
            tick();
        end
        rsp1_ready = 0;
        @(negedge clk);
        checks++;
        if ({a_busy, a_req0_ready} !== 2'b01) begin
            fails++; $display("FAIL bp_idle: got busy=%b r0=%b want 0 1", a_busy, a_req0_ready);
        end
        req0_valid = 0;   // withdraw without handshake
        tick();
        @(negedge clk);
        checks++;
        if (a_busy !== 1'b0) begin
            fails++; $display("FAIL bp_withdraw: got busy=%b want 0", a_busy);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_timeout();
        int n;
        reset_dut();
        // handshake on the last allowed cycle still delivers
        req0_valid = 1; req0_op = OP_ADD; req0_src1 = 2; req0_src2 = 3;
        @(negedge clk);
        checks++;
        if (b_req0_ready !== 1'b1) begin
            fails++; $display("FAIL to_grant: got %b want 1", b_req0_ready);
        end
        tick();
        req0_valid = 0;
        tick();
        tick(); tick(); tick();
        rsp0_ready = 1;
        @(negedge clk);
        checks++;
        if ({b_rsp0_valid, b_rsp_data} !== {1'b1, 32'd5}) begin
            fails++; $display("FAIL to_last_cycle: got v=%b d=%0d want 1 5", b_rsp0_valid, b_rsp_data);
        end
        tick();
        rsp0_ready = 0;
        @(negedge clk);
        checks++;
        if ({b_busy, b_drop_err} !== 2'b00) begin
            fails++; $display("FAIL to_delivered: got busy=%b drop=%b want 0 0", b_busy, b_drop_err);
        end
        tick();
        // never accepted: dropped after 4 DONE cycles
        req0_valid = 1;
        @(negedge clk);
        tick();
        req0_valid = 0;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (b_rsp0_valid) n++;
            else if (n > 0) break;
            tick();
        end
        checks++;
        if ({n, b_busy, b_drop_err} !== {32'd4, 1'b0, 1'b1}) begin
            fails++; $display("FAIL to_drop: got cycles=%0d busy=%b drop=%b want 4 0 1", n, b_busy, b_drop_err);
        end
        tick();
        req1_valid = 1; req1_op = OP_ADD; req1_src1 = 10; req1_src2 = 20; rsp1_ready = 1;
        @(negedge clk);
        checks++;
        if ({b_req0_ready, b_req1_ready} !== 2'b01) begin
            fails++; $display("FAIL to_next_grant: got %b want 01", {b_req0_ready, b_req1_ready});
        end
        tick();
        req1_valid = 0;
        tick();
        @(negedge clk);
        checks++;
        if ({b_rsp1_valid, b_rsp_data, b_drop_err} !== {1'b1, 32'd30, 1'b1}) begin
            fails++; $display("FAIL to_next_rsp: got v=%b d=%0d drop=%b want 1 30 1", b_rsp1_valid, b_rsp_data, b_drop_err);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({b_busy, b_drop_err} !== 2'b01) begin
            fails++; $display("FAIL to_sticky: got busy=%b drop=%b want 0 1", b_busy, b_drop_err);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        reset_dut();
        req0_valid = 1; req0_op = OP_ADD; req0_src1 = 5; req0_src2 = 7; rsp0_ready = 1;
        tick();
        req0_valid = 0;
        tick(); tick();
        req0_valid = 1; req0_src1 = 1; req0_src2 = 2;
        tick();
        req0_valid = 0;
        // now in EXEC
        #2;
        rst_n = 0;
        #1;
        checks++;
        if ({a_busy, a_rsp0_valid, a_rsp1_valid, a_ctr, a_src1, a_src2, a_rsp_data, a_rsp_equal} !== '0) begin
            fails++; $display("FAIL midrst_async: got busy=%b ctr=%b s1=%h d=%h want 0", a_busy, a_ctr, a_src1, a_rsp_data);
        end
        tick();
        rst_n = 1;
        req0_valid = 1; req1_valid = 1; req1_op = OP_SLT;
        @(negedge clk);
        checks++;
        if ({a_req0_ready, a_req1_ready} !== 2'b10) begin
            fails++; $display("FAIL midrst_tie: got %b want 10", {a_req0_ready, a_req1_ready});
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_illegal();
        reset_dut();
        req1_valid = 1; req1_op = OP_BAD; req1_src1 = 32'hFFFF_FFFF; req1_src2 = 32'hFFFF_FFFF; rsp1_ready = 1;
        tick();
        req1_valid = 0;
        tick();
        @(negedge clk);
        checks++;
        if ({a_rsp1_valid, a_rsp_equal, a_rsp_data} !== {1'b1, 1'b1, 32'd0}) begin
            fails++; $display("FAIL illegal_op: got v=%b eq=%b d=%h want 1 1 0", a_rsp1_valid, a_rsp_equal, a_rsp_data);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_random();
        int last, w, n;
        logic v0, v1;
        logic [DW:0] e;
        reset_dut();
        last = 1;
        for (int t = 0; t < 40; t++) begin
            v0 = 1'($urandom_range(0, 1)); v1 = 1'($urandom_range(0, 1));
            req0_op = ops[$urandom_range(0, 7)]; req1_op = ops[$urandom_range(0, 7)];
            req0_shamt = 5'($urandom); req1_shamt = 5'($urandom);
            req0_src1 = $urandom; req0_src2 = ($urandom_range(0, 3) == 0) ? req0_src1 : $urandom;
            req1_src1 = $urandom; req1_src2 = ($urandom_range(0, 3) == 0) ? req1_src1 : $urandom;
            req0_valid = v0; req1_valid = v1; rsp0_ready = 0; rsp1_ready = 0;
            @(negedge clk);
            if (!v0 && !v1) begin
                checks++;
                if ({a_req0_ready, a_req1_ready, a_busy} !== 3'b000) begin
                    fails++; $display("FAIL rnd_noreq%0d: got r=%b%b busy=%b want 000", t, a_req0_ready, a_req1_ready, a_busy);
                end
                tick();
                continue;
            end
            w = (v0 && v1) ? ((last == 0) ? 1 : 0) : (v1 ? 1 : 0);
            e = (w == 1) ? alu_fn(req1_op, req1_shamt, req1_src1, req1_src2)
                         : alu_fn(req0_op, req0_shamt, req0_src1, req0_src2);
            checks++;
            if ({a_req0_ready, a_req1_ready} !== ((w == 1) ? 2'b01 : 2'b10)) begin
                fails++; $display("FAIL rnd_grant%0d: got %b want winner %0d", t, {a_req0_ready, a_req1_ready}, w);
            end
            last = w;
            tick();
            req0_valid = 1'($urandom_range(0, 1)); req1_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++;
            if ({a_req0_ready, a_req1_ready, a_rsp0_valid, a_rsp1_valid, a_busy} !== 5'b00001) begin
                fails++; $display("FAIL rnd_exec%0d: got %b want 00001", t, {a_req0_ready, a_req1_ready, a_rsp0_valid, a_rsp1_valid, a_busy});
            end
            tick();
            n = $urandom_range(0, 3);
            for (int j = 0; j <= n; j++) begin
                if (w == 1) begin rsp1_ready = (j == n); rsp0_ready = 1'($urandom_range(0, 1)); end
                else        begin rsp0_ready = (j == n); rsp1_ready = 1'($urandom_range(0, 1)); end
                @(negedge clk);
                checks++;
                if ({a_rsp0_valid, a_rsp1_valid, a_req0_ready, a_req1_ready, a_rsp_equal, a_rsp_data} !== {(w == 0), (w == 1), 2'b00, e}) begin
                    fails++; $display("FAIL rnd_rsp%0d: got v=%b%b r=%b%b eq=%b d=%h want owner %0d eq=%b d=%h", t, a_rsp0_valid, a_rsp1_valid, a_req0_ready, a_req1_ready, a_rsp_equal, a_rsp_data, w, e[DW], e[DW-1:0]);
                end
                tick();
            end
        end
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        test_illegal();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
